// File: rtl/bounce_emulator.sv
// bounce_emulator: turns each clean level change into a glitch burst
// of ON/OFF phases, fixed or LFSR-timed, then settles at the new level.
module bounce_emulator #(
  parameter int         BOUNCES   = 3,
  parameter int         MAX_PULSE = 4,
  parameter bit         RANDOM    = 1'b0,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clean_in,
  output logic       noisy_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] burst_cnt
);

  localparam int PW = $clog2(MAX_PULSE);
  localparam logic [7:0] SEED_EFF =
    (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [PW-1:0] FIXED_M1 =
    PW'(MAX_PULSE - 1);
  localparam logic [3:0] GLITCHES = 4'(BOUNCES);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } state_t;

  state_t        r_state;
  logic          r_noisy;
  logic          r_busy;
  logic          r_done;
  logic          r_target;
  logic          r_new;
  logic [7:0]    r_cnt;
  logic [7:0]    r_lfsr;
  logic [PW-1:0] r_phase;
  logic [3:0]    r_glitch;

  logic [7:0]    w_lfsr_next;
  logic [PW-1:0] w_len_m1;
  logic          w_start;

  // Galois form of x^8+x^6+x^5+x^4+1, shifting right
  assign w_lfsr_next = {
    r_lfsr[0],
    r_lfsr[7],
    r_lfsr[6] ^ r_lfsr[0],
    r_lfsr[5] ^ r_lfsr[0],
    r_lfsr[4] ^ r_lfsr[0],
    r_lfsr[3:1]
  };

  // phase counter holds length-1 and expires on zero
  assign w_len_m1 = RANDOM ? r_lfsr[PW-1:0]
                           : FIXED_M1;
  assign w_start  = en && (clean_in != r_target);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_noisy  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_target <= 1'b0;
      r_new    <= 1'b0;
      r_cnt    <= 8'd0;
      r_lfsr   <= SEED_EFF;
      r_phase  <= '0;
      r_glitch <= 4'd0;
    end else begin
      r_lfsr <= w_lfsr_next;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            if (GLITCHES == 4'd0) begin
              r_noisy  <= clean_in;
              r_target <= clean_in;
              r_done   <= 1'b1;
              r_cnt    <= r_cnt + 8'd1;
            end else begin
              r_new    <= clean_in;
              r_noisy  <= clean_in;
              r_busy   <= 1'b1;
              r_glitch <= GLITCHES;
              r_phase  <= w_len_m1;
              r_state  <= ON;
            end
          end
        end
        ON: begin
          if (r_phase == '0) begin
            r_noisy <= ~r_new;
            r_phase <= w_len_m1;
            r_state <= OFF;
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
        OFF: begin
          if (r_phase == '0) begin
            r_glitch <= r_glitch - 4'd1;
            r_noisy  <= r_new;
            if (r_glitch == 4'd1) begin
              r_target <= r_new;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_cnt    <= r_cnt + 8'd1;
              r_state  <= IDLE;
            end else begin
              r_phase <= w_len_m1;
              r_state <= ON;
            end
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign noisy_out = r_noisy;
  assign busy      = r_busy;
  assign done      = r_done;
  assign burst_cnt = r_cnt;

endmodule

// File: doc/bounce_emulator.md
# bounce_emulator

Synthesizable contact-bounce generator, the stimulus end of the switch-input path. On each change of an ideal level input, it drives a noisy output through a burst of glitch pulses before settling at the new level. It feeds debounce logic in benches and FPGA self-test builds, so rejection can be exercised on hardware without a physical switch. Glitch lengths are either fixed or drawn from an on-chip LFSR.

## Interface
- BOUNCES, default 3: glitch pulses per transition, range 0..15.
- MAX_PULSE, default 4: maximum phase length in cycles; must be a power of two, ≥2.
- RANDOM, default 0: 0 = every phase lasts MAX_PULSE cycles; 1 = phase length drawn from the LFSR.
- SEED, default 8'hA5: LFSR reset value; 8'h00 is replaced by 8'h01.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  allows a new burst to start; does not abort a running burst.
- clean_in  in  1  ideal target level.
- noisy_out  out  1  bouncy emulated switch output, registered.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when noisy_out settles at the new level.
- burst_cnt  out  8  completed bursts; wraps 255→0.

## Operation
- State: FSM {IDLE, ON, OFF}, plus the following registers:
  - target (committed level);
  - new_lvl;
  - phase counter, width $clog2(MAX_PULSE);
  - glitch counter, 4 bits;
  - 8-bit Galois LFSR, taps x^8+x^6+x^5+x^4+1.
- Reset values:
  - noisy_out=0, target=0, busy=0, done=0, burst_cnt=0.
  - state=IDLE, LFSR=SEED (or 8'h01 if SEED==0).
- LFSR advances every non-reset cycle, independent of state.
- Phase length len:
  - RANDOM=0: MAX_PULSE.
  - RANDOM=1: LFSR[$clog2(MAX_PULSE)-1:0]+1, i.e. 1..MAX_PULSE.
  - Sampled from the current LFSR value whenever a phase is loaded.
- IDLE, start condition: en=1 and clean_in≠target.
  - BOUNCES==0: noisy_out←clean_in, target←clean_in, done←1, burst_cnt+1, stay IDLE.
  - Otherwise: new_lvl←clean_in, noisy_out←clean_in, busy←1, glitch counter←BOUNCES, load phase counter, go to ON.
- ON: phase counter decrements. At expiry: noisy_out←~new_lvl, load phase, go to OFF.
- OFF: phase counter decrements. At expiry:
  - Decrement glitch counter.
  - If the glitch counter is now 0: noisy_out←new_lvl, target←new_lvl, busy←0, done←1, burst_cnt+1, go to IDLE.
  - Else: noisy_out←new_lvl, load phase, go to ON.
- done: high for exactly one cycle, otherwise 0.
- clean_in changes during a burst are ignored; new_lvl is held.
  - Back in IDLE, if clean_in≠target, the next burst starts on the following edge (minimum one idle cycle between bursts).
- en deasserted mid-burst: the burst completes normally.
- rst asserted mid-burst: every register takes its reset value at that edge. noisy_out=0 even if target was 1.
- clean_in stable (equal to target): noisy_out is constant and busy=0, indefinitely.

## Timing
- Start edge E0 (clean_in≠target sampled, en=1): noisy_out=new level and busy=1 from E0.
- RANDOM=0, per-phase boundaries:
  - ON phases occupy [E0+2k·L, E0+(2k+1)·L).
  - OFF phases occupy [E0+(2k+1)·L, E0+(2k+2)·L), for k=0..BOUNCES-1, L=MAX_PULSE.
- Settle edge ES = E0+2·BOUNCES·L:
  - noisy_out=new level steady from ES.
  - busy=0 and done=1 during the cycle after ES; burst_cnt increments at ES.
- Burst length:
  - RANDOM=0: exactly 2·BOUNCES·MAX_PULSE cycles.
  - RANDOM=1: between 2·BOUNCES and 2·BOUNCES·MAX_PULSE cycles.
- Latency from clean_in sample to first noisy_out change: 1 edge (registered output, no combinational path).

## Test plan
- **Fixed burst, rising:** Defaults. After rst, clean_in 0→1 with en=1 at edge E0.
  - noisy_out = 1×4, 0×4, 1×4, 0×4, 1×4, 0×4 cycles, then steady 1 from E0+24.
  - done pulses once; burst_cnt=1.
  - The mirror 1→0 transition gives the inverted pattern and burst_cnt=2.
- **BOUNCES=0:** clean_in toggles.
  - noisy_out follows with 1-cycle latency; done every toggle; busy never 1.
- **Mid-burst input change:** clean_in 0→1, then back to 0 at E0+5.
  - First burst completes to 1 at E0+24.
  - Second burst starts at E0+25 toward 0; burst_cnt=2 after E0+49.
- **Enable and reset:**
  - en=0 while clean_in changes: no activity.
  - en 1→0 at E0+3: burst still completes.
  - rst at E0+10: noisy_out=0, busy=0, burst_cnt=0 on the next cycle.
- **RANDOM=1, MAX_PULSE=8, SEED=8'hA5:**
  - Every phase length is within 1..8 and matches the reference LFSR model cycle-for-cycle.
  - With SEED=0, behaviour is identical to SEED=8'h01.
- **Loopback:** drive a debouncer with threshold N=MAX_PULSE+1.
  - Its output changes exactly once per burst, never during glitches.
